sort_issue_ctrl: RTL and testbench

Issue controller for the 8-lane valid-compaction sort pipeline in the BFS update path. Accepts 8-lane update beats from the edge-processing stage over a valid/ready handshake and meters them into the sort pipeline against downstream FIFO credits, since that pipeline has no backpressure. Frames each phase with `start` and `last`, drains the pipeline, and pulses `phase_done` once the last beat has emerged.

---
 rtl/bfs_pkg.sv | 21 ++
 rtl/sort_issue_ctrl_credit_counter.sv | 39 +++
 rtl/sort_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_sort_issue_ctrl.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfs_pkg.sv
// Shared types and constants for the BFS update path.
// Lane packing, control codes and the sort issue FSM states.
package bfs_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 33;
  localparam int BEAT_W = LANES * LANE_W;

  localparam logic [1:0] CTRL_NONE  = 2'b00;
  localparam logic [1:0] CTRL_SCAN  = 2'b01;
  localparam logic [1:0] CTRL_MERGE = 2'b10;
  localparam logic [1:0] CTRL_FLUSH = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } sort_issue_state_t;

endpackage

// File: rtl/sort_issue_ctrl_credit_counter.sv
// Up/down credit counter for the FIFO behind the sort pipeline.
// Starts full, saturates at DEPTH, flags zero credits.
module credit_counter #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic dec,
  input  logic inc,
  output logic zero
);

  localparam logic [CW-1:0] MAX = CW'(DEPTH);

  logic [CW-1:0] count;

  // take a credit per issued beat, return one per FIFO pop
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= MAX;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end else if (inc && !dec && count != MAX) begin
      count <= count + 1'b1;
    end
  end

  assign zero = (count == '0);

  // a pop with the FIFO already fully credited means lost accounting
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(inc && !dec && count == MAX));
      assert (!(dec && !inc && count == '0));
    end
  end

endmodule

// File: rtl/sort_issue_ctrl.sv
// Meters 8-lane update beats into the sort pipeline against FIFO credits.
// Optional stall statistics under SORT_ISSUE_STATS_EN.
module sort_issue_ctrl
  import bfs_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PIPE_LAT   = 6,
  parameter int CW         = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        phase_ctrl,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [BEAT_W-1:0] in_data,
  output logic [BEAT_W-1:0] sort_data,
  output logic              sort_word_in_valid,
  output logic              sort_last_input,
  output logic [1:0]        sort_control,
  output logic [31:0]       sort_th,
  input  logic              sort_valid_out,
  input  logic              sort_last_out,
  input  logic              fifo_pop,
  output logic              busy,
  output logic              phase_done,
  output logic [31:0]       beats_issued,
  output logic [31:0]       stall_cycles
);

  if (FIFO_DEPTH >= (1 << CW) || PIPE_LAT < 1) begin : g_cfg_err
    $error("sort_issue_ctrl: bad FIFO_DEPTH/CW/PIPE_LAT");
  end

  sort_issue_state_t state;
  logic              cred_zero;
  logic              fire;

  assign in_ready = (state == S_RUN) && !cred_zero;
  assign fire     = in_valid && in_ready;
  assign busy     = (state != S_IDLE);

  credit_counter #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_cred (
    .clk  (clk),
    .rst  (rst),
    .dec  (fire),
    .inc  (fifo_pop),
    .zero (cred_zero)
  );

  // phase FSM plus the issue register feeding the sort lanes
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      sort_data          <= '0;
      sort_word_in_valid <= 1'b0;
      sort_last_input    <= 1'b0;
      sort_control       <= CTRL_NONE;
      sort_th            <= '0;
      phase_done         <= 1'b0;
      beats_issued       <= '0;
    end else begin
      sort_data          <= fire ? in_data : '0;
      sort_word_in_valid <= fire;
      sort_last_input    <= fire && in_last;
      phase_done         <= 1'b0;
      if (fire) begin
        sort_th      <= beats_issued;
        beats_issued <= beats_issued + 32'd1;
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_RUN;
            sort_control <= phase_ctrl;
            beats_issued <= '0;
            sort_th      <= '0;
          end
        end
        S_RUN: begin
          if (fire && in_last) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (sort_valid_out && sort_last_out) begin
            state      <= S_DONE;
            phase_done <= 1'b1;
          end
        end
        S_DONE: begin
          state        <= S_IDLE;
          sort_control <= CTRL_NONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SORT_ISSUE_STATS_EN
  logic [31:0] stall_q;

  // cycles where upstream had a beat but credits were exhausted
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state == S_IDLE && start) begin
      stall_q <= '0;
    end else if (state == S_RUN && in_valid && !in_ready
                 && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sort_issue_ctrl.sv
// Bench for sort_issue_ctrl with a modelled 6-cycle sort pipeline.
// Issued beats are scoreboarded and compared as they leave the issue register.
module tb_sort_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int LAT   = 6;
  localparam int BW    = 264;

  typedef struct packed {
    logic [BW-1:0] d;
    logic          l;
    logic [31:0]   th;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    phase_ctrl;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [BW-1:0] in_data;
  logic [BW-1:0] sort_data;
  logic          sort_word_in_valid;
  logic          sort_last_input;
  logic [1:0]    sort_control;
  logic [31:0]   sort_th;
  logic          sort_valid_out;
  logic          sort_last_out;
  logic          fifo_pop;
  logic          busy;
  logic          phase_done;
  logic [31:0]   beats_issued;
  logic [31:0]   stall_cycles;

  logic          manual_pop;
  logic          pop_en;
  logic [LAT-1:0] vp;
  logic [LAT-1:0] lp;

  beat_t         sb[$];
  int            total = 0;
  int            pass  = 0;
  int            exp_th;
  int            stalls;

  always #5 clk = ~clk;

  sort_issue_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .PIPE_LAT   (LAT),
    .CW         (5)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .phase_ctrl         (phase_ctrl),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_last            (in_last),
    .in_data            (in_data),
    .sort_data          (sort_data),
    .sort_word_in_valid (sort_word_in_valid),
    .sort_last_input    (sort_last_input),
    .sort_control       (sort_control),
    .sort_th            (sort_th),
    .sort_valid_out     (sort_valid_out),
    .sort_last_out      (sort_last_out),
    .fifo_pop           (fifo_pop),
    .busy               (busy),
    .phase_done         (phase_done),
    .beats_issued       (beats_issued),
    .stall_cycles       (stall_cycles)
  );

  // sort pipeline model: fixed latency, flushed by rst
  always @(posedge clk) begin
    if (rst) begin
      vp <= '0;
      lp <= '0;
    end else begin
      vp <= {vp[LAT-2:0], sort_word_in_valid};
      lp <= {lp[LAT-2:0], sort_last_input};
    end
  end

  assign sort_valid_out = vp[LAT-1];
  assign sort_last_out  = lp[LAT-1];
  assign fifo_pop       = manual_pop | (pop_en & sort_valid_out);

  // scoreboard: every issued beat must match what was accepted
  always @(negedge clk) begin
    if (!rst) begin
      if (sort_word_in_valid) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: beat issued with th=%0d, none expected",
                   sort_th);
        end else begin
          beat_t e;
          e = sb.pop_front();
          if (sort_data !== e.d || sort_last_input !== e.l
              || sort_th !== e.th)
            $display("FAIL sb_beat: got th=%0d last=%0b lane0=%h, want th=%0d last=%0b lane0=%h",
                     sort_th, sort_last_input, sort_data[32:0],
                     e.th, e.l, e.d[32:0]);
          else pass++;
        end
      end else begin
        total++;
        if (sort_data !== '0 || sort_last_input !== 1'b0)
          $display("FAIL sb_idle: data=%h last=%0b, want 0/0",
                   sort_data[32:0], sort_last_input);
        else pass++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", pass, total);
    $fatal(1);
  end

  function automatic logic [BW-1:0] mk(input int i);
    logic [BW-1:0] d;
    d = '0;
    d[32:0]    = {32'hA, 1'b1};
    d[65:33]   = {32'(i * 7 + 3), 1'(i % 2)};
    d[263:231] = {32'(i), 1'b0};
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    start      = 1'b0;
    phase_ctrl = 2'b00;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_data    = '0;
    manual_pop = 1'b0;
    pop_en     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    sb.delete();
    exp_th = 0;
    stalls = 0;
  endtask

  task automatic start_phase(input logic [1:0] code);
    @(negedge clk);
    start      = 1'b1;
    phase_ctrl = code;
    @(negedge clk);
    start  = 1'b0;
    exp_th = 0;
    stalls = 0;
  endtask

  task automatic offer(input logic [BW-1:0] d, input logic last,
                       input logic pop, output bit fired);
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = d;
    in_last    = last;
    manual_pop = pop;
    #1;
    fired = in_ready;
    if (fired) begin
      sb.push_back('{d: d, l: last, th: 32'(exp_th)});
      exp_th++;
    end else begin
      stalls++;
    end
  endtask

  task automatic wait_done(output int k);
    k = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        in_valid   = 1'b0;
        in_last    = 1'b0;
        manual_pop = 1'b0;
      end
      if (phase_done) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({in_ready, busy, phase_done, sort_word_in_valid, sort_last_input} !== 5'b0)
      $display("FAIL rst_flags: ready/busy/done/valid/last=%b, want 00000",
               {in_ready, busy, phase_done, sort_word_in_valid, sort_last_input});
    else pass++;
    total++;
    if (sort_data !== '0 || sort_control !== 2'b00 || sort_th !== 32'd0
        || beats_issued !== 32'd0 || stall_cycles !== 32'd0)
      $display("FAIL rst_values: ctrl=%0d th=%0d issued=%0d stall=%0d, want all 0",
               sort_control, sort_th, beats_issued, stall_cycles);
    else pass++;
    @(negedge clk);
    start      = 1'b1;
    phase_ctrl = 2'b01;
    #1;
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL rst_start_same: in_ready=%0b, want 0", in_ready);
    else pass++;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || sort_control !== 2'b01)
      $display("FAIL rst_start_next: ready=%0b busy=%0b ctrl=%0d, want 1 1 1",
               in_ready, busy, sort_control);
    else pass++;
  endtask

  task automatic test_three_beat();
    bit f;
    int k;
    do_reset();
    pop_en = 1'b1;
    start_phase(2'b01);
    for (int i = 0; i < 3; i++) begin
      offer(mk(i), i == 2, 1'b0, f);
      total++;
      if (!f) $display("FAIL three_fire: beat %0d not accepted, want accepted", i);
      else pass++;
    end
    wait_done(k);
    total++;
    if (k !== 8) $display("FAIL three_done_lat: phase_done at +%0d, want +8", k);
    else pass++;
    total++;
    if (beats_issued !== 32'd3)
      $display("FAIL three_issued: beats_issued=%0d, want 3", beats_issued);
    else pass++;
    @(negedge clk);
    total++;
    if (phase_done !== 1'b0 || busy !== 1'b0 || sort_control !== 2'b00)
      $display("FAIL three_after: done=%0b busy=%0b ctrl=%0d, want 0 0 0",
               phase_done, busy, sort_control);
    else pass++;
  endtask

  task automatic test_single_beat();
    bit f;
    int k;
    do_reset();
    pop_en = 1'b1;
    start_phase(2'b11);
    offer('0, 1'b1, 1'b0, f);
    total++;
    if (!f) $display("FAIL single_fire: empty beat not accepted, want accepted");
    else pass++;
    wait_done(k);
    total++;
    if (k !== 8) $display("FAIL single_done_lat: phase_done at +%0d, want +8", k);
    else pass++;
    total++;
    if (beats_issued !== 32'd1 || sort_control !== 2'b11)
      $display("FAIL single_state: issued=%0d ctrl=%0d, want 1 3",
               beats_issued, sort_control);
    else pass++;
  endtask

  task automatic test_credit_stall();
    bit f;
    int k;
    int exp_stall;
    do_reset();
    start_phase(2'b00);
    for (int i = 0; i < 4; i++) begin
      offer(mk(i), 1'b0, 1'b0, f);
      total++;
      if (!f) $display("FAIL credit_fill: beat %0d not accepted, want accepted", i);
      else pass++;
    end
    for (int j = 0; j < 3; j++) begin
      offer(mk(4), 1'b0, j == 2, f);
      total++;
      if (f) $display("FAIL credit_block: accepted at 0 credits (try %0d), want blocked", j);
      else pass++;
    end
    offer(mk(4), 1'b0, 1'b0, f);
    total++;
    if (!f) $display("FAIL credit_one_pop: not accepted after pop, want accepted");
    else pass++;
    offer(mk(5), 1'b1, 1'b0, f);
    total++;
    if (f) $display("FAIL credit_one_only: second beat accepted after one pop, want blocked");
    else pass++;
    offer(mk(5), 1'b1, 1'b1, f);
    offer(mk(5), 1'b1, 1'b0, f);
    total++;
    if (!f) $display("FAIL credit_last: last beat not accepted after pop, want accepted");
    else pass++;
    wait_done(k);
    total++;
    if (k !== 8) $display("FAIL credit_done_lat: phase_done at +%0d, want +8", k);
    else pass++;
`ifdef SORT_ISSUE_STATS_EN
    exp_stall = stalls;
`else
    exp_stall = 0;
`endif
    total++;
    if (stall_cycles !== 32'(exp_stall) || beats_issued !== 32'd6)
      $display("FAIL credit_stats: stall=%0d issued=%0d, want %0d 6",
               stall_cycles, beats_issued, exp_stall);
    else pass++;
  endtask

  task automatic test_fire_and_pop();
    bit f;
    int k;
    do_reset();
    start_phase(2'b01);
    for (int i = 0; i < 3; i++) offer(mk(10 + i), 1'b0, 1'b0, f);
    offer(mk(13), 1'b0, 1'b1, f);
    total++;
    if (!f) $display("FAIL fp_fire: beat with 1 credit not accepted, want accepted");
    else pass++;
    offer(mk(14), 1'b1, 1'b0, f);
    total++;
    if (!f) $display("FAIL fp_keep: credit lost on fire+pop, in_ready=0, want 1");
    else pass++;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL fp_drain: ready=%0b busy=%0b, want 0 1", in_ready, busy);
    else pass++;
    wait_done(k);
    total++;
    if (k === -1) $display("FAIL fp_done: phase_done never seen, want pulse");
    else pass++;
  endtask

  task automatic test_start_ignored();
    bit f;
    int k;
    do_reset();
    pop_en = 1'b1;
    start_phase(2'b01);
    offer(mk(20), 1'b0, 1'b0, f);
    offer(mk(21), 1'b0, 1'b0, f);
    @(negedge clk);
    in_valid   = 1'b0;
    start      = 1'b1;
    phase_ctrl = 2'b10;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (sort_control !== 2'b01 || beats_issued !== 32'd2 || in_ready !== 1'b1)
      $display("FAIL ign_start: ctrl=%0d issued=%0d ready=%0b, want 1 2 1",
               sort_control, beats_issued, in_ready);
    else pass++;
    offer(mk(22), 1'b1, 1'b0, f);
    wait_done(k);
    total++;
    if (k !== 8 || beats_issued !== 32'd3)
      $display("FAIL ign_finish: done at +%0d issued=%0d, want +8 3",
               k, beats_issued);
    else pass++;
  endtask

  task automatic test_rst_drain();
    bit f;
    bit seen;
    int k;
    int n;
    do_reset();
    pop_en = 1'b1;
    start_phase(2'b11);
    offer(mk(30), 1'b0, 1'b0, f);
    offer(mk(31), 1'b1, 1'b0, f);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL rd_drain: busy=%0b ready=%0b, want 1 0", busy, in_ready);
    else pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    total++;
    if (busy !== 1'b0 || sort_control !== 2'b00 || in_ready !== 1'b0)
      $display("FAIL rd_idle: busy=%0b ctrl=%0d ready=%0b, want 0 0 0",
               busy, sort_control, in_ready);
    else pass++;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (phase_done) seen = 1'b1;
    end
    total++;
    if (seen) $display("FAIL rd_no_done: phase_done after rst=1, want 0");
    else pass++;
    start_phase(2'b01);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      offer(mk(40 + i), i == 3, 1'b0, f);
      if (f) n++;
    end
    total++;
    if (n !== DEPTH)
      $display("FAIL rd_credits: %0d back-to-back fires, want %0d", n, DEPTH);
    else pass++;
    wait_done(k);
    total++;
    if (k !== 8) $display("FAIL rd_done_lat: phase_done at +%0d, want +8", k);
    else pass++;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    phase_ctrl = 2'b00;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_data    = '0;
    manual_pop = 1'b0;
    pop_en     = 1'b0;
    test_reset();
    test_three_beat();
    test_single_beat();
    test_credit_stall();
    test_fire_and_pop();
    test_start_ignored();
    test_rst_drain();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0)
      $display("FAIL sb_leftover: %0d beats never issued, want 0", sb.size());
    else pass++;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
